// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads, plotter writes, clear engine.
// Grants at most one RAM access per cycle and drives registered mem_* outputs.
module fb_port_arbiter #(
    parameter int                 ADDR_W     = 19,
    parameter int                 DATA_W     = 8,
    parameter int                 DEPTH      = 307200,
    parameter logic [DATA_W-1:0]  CLR_VALUE  = '0,
    parameter int                 STARVE_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] sc_addr,
    output logic [DATA_W-1:0] sc_rdata,
    output logic              sc_rvalid,
    input  logic              pl_valid,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [DATA_W-1:0] pl_wdata,
    output logic              pl_ready,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              starve_flag,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                SW    = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [SW-1:0]     SMAX  = SW'(STARVE_MAX);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic              en_q, en_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              v1_q, rv_q;
    logic              done_q, done_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              flag_q, flag_d;
    logic              clr_go, clr_last, pl_go, stall;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clr_start) state_d = S_CLEAR;
            S_CLEAR: if (clr_go && clr_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pl_ready = !rst && !sc_req && (state_q == S_IDLE);
        clr_busy = (state_q == S_CLEAR);
        clr_go   = (state_q == S_CLEAR) && !sc_req;
        clr_last = (caddr_q == LAST);
        pl_go    = pl_valid && pl_ready;
        stall    = pl_valid && !pl_ready;
    end

    // One grant per cycle: scanout, then clear, then plotter.
    always_comb begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        caddr_d = caddr_q;
        if (sc_req) begin
            en_d   = 1'b1;
            addr_d = sc_addr;
        end else if (clr_go) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = caddr_q;
            wdata_d = CLR_VALUE;
            done_d  = clr_last;
            caddr_d = clr_last ? '0 : caddr_q + 1'b1;
        end else if (pl_go) begin
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = pl_addr;
            wdata_d = pl_wdata;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (stall) cnt_d = (cnt_q == SMAX) ? cnt_q : cnt_q + 1'b1;
        flag_d = flag_q || (cnt_d == SMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            caddr_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            v1_q    <= 1'b0;
            rv_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            caddr_q <= caddr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            v1_q    <= sc_req;
            rv_q    <= v1_q;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    assign mem_en      = en_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign sc_rvalid   = rv_q;
    assign sc_rdata    = mem_rdata;
    assign clr_done    = done_q;
    assign starve_flag = flag_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised bench for fb_port_arbiter against a cycle-level reference model.
// Small DEPTH/STARVE_MAX so clear and starvation corners are reachable.
module tb_fb_port_arbiter;

    localparam int          AW    = 10;
    localparam int          DW    = 8;
    localparam int          DEPTH = 16;
    localparam int          SMAX  = 8;
    localparam logic [7:0]  CLRV  = 8'h3C;

    logic          clk = 1'b0;
    logic          rst;
    logic          sc_req;
    logic [AW-1:0] sc_addr;
    logic [DW-1:0] sc_rdata;
    logic          sc_rvalid;
    logic          pl_valid;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_wdata;
    logic          pl_ready;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          starve_flag;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
        .CLR_VALUE(CLRV), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .sc_req(sc_req), .sc_addr(sc_addr),
        .sc_rdata(sc_rdata), .sc_rvalid(sc_rvalid),
        .pl_valid(pl_valid), .pl_addr(pl_addr),
        .pl_wdata(pl_wdata), .pl_ready(pl_ready),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .clr_done(clr_done), .starve_flag(starve_flag),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] ram_f(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h86;
    endfunction

    // RAM model with 1-cycle synchronous read
    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= ram_f(mem_addr);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    bit            m_ok = 0;
    bit            m_en = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_v1 = 0, m_rv = 0;
    logic [DW-1:0] m_d1 = '0, m_rd = '0;
    bit            m_clr = 0;
    int            m_caddr = 0;
    bit            m_done = 0;
    int            m_cnt = 0;
    bit            m_flag = 0;
    bit            m_pend = 0;

    bit track = 0;
    int seen_wr = 0;
    int done_obs = 0;

    task automatic model_step();
        bit ready, was;
        ready  = !rst && !sc_req && !m_clr;
        was    = m_clr;
        m_pend = pl_valid && !ready;
        m_ok   = 1;
        if (rst) begin
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_v1 = 0; m_rv = 0; m_clr = 0; m_caddr = 0;
            m_done = 0; m_cnt = 0; m_flag = 0;
            return;
        end
        m_rd = m_d1; m_rv = m_v1;
        m_v1 = sc_req; m_d1 = ram_f(sc_addr);
        m_en = 0; m_we = 0; m_done = 0;
        if (sc_req) begin
            m_en = 1; m_addr = sc_addr;
        end else if (was) begin
            m_en = 1; m_we = 1;
            m_addr = AW'(m_caddr); m_wdata = CLRV;
            if (m_caddr == DEPTH - 1) begin
                m_clr = 0; m_caddr = 0; m_done = 1;
            end else m_caddr++;
        end else if (pl_valid) begin
            m_en = 1; m_we = 1;
            m_addr = pl_addr; m_wdata = pl_wdata;
        end
        if (!was && clr_start) m_clr = 1;
        if (pl_valid && !ready) m_cnt = (m_cnt < SMAX) ? m_cnt + 1 : SMAX;
        else m_cnt = 0;
        if (m_cnt == SMAX) m_flag = 1;
    endtask

    task automatic step();
        @(negedge clk);
        chk("pl_ready", pl_ready, !rst && !sc_req && !m_clr);
        if (m_ok) begin
            chk("mem_en", mem_en, m_en);
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("sc_rvalid", sc_rvalid, m_rv);
            if (m_rv) chk("sc_rdata", sc_rdata, m_rd);
            chk("clr_busy", clr_busy, m_clr);
            chk("clr_done", clr_done, m_done);
            chk("starve", starve_flag, m_flag);
        end
        if (track && mem_we) begin
            chk("clr_seq_addr", mem_addr, seen_wr);
            chk("clr_seq_data", mem_wdata, CLRV);
            seen_wr++;
        end
        if (clr_done) done_obs++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sc_req = 0; clr_start = 0;
        if (!m_pend) pl_valid = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1; idle_in(); pl_valid = 0;
        repeat (n) step();
        rst = 0;
    endtask

    task automatic run_clear(input bit rand_sc, input bit restart5);
        int k;
        bit fin;
        fin = 0;
        for (k = 0; k < 200 && !fin; k++) begin
            sc_req    = rand_sc ? 1'($urandom) : 1'b0;
            clr_start = restart5 && m_clr && m_caddr == 5;
            step();
            fin = m_done;
        end
        clr_start = 0; sc_req = 0;
        if (!fin) chk("clr_timeout", 1, 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        rst = 1; sc_req = 0; sc_addr = '0; pl_valid = 1;
        pl_addr = '0; pl_wdata = '0; clr_start = 0;
        #1;
        do_reset(3);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_flag", starve_flag, 0);

        // Scanout priority over a waiting plotter
        pl_valid = 1; pl_addr = 10'h2AB; pl_wdata = 8'h77;
        sc_req = 1; sc_addr = 10'h040;
        repeat (20) begin
            step();
            chk("prio_no_we", mem_we, 0);
        end
        sc_req = 0;
        step();
        pl_valid = 0;
        chk("prio_we", mem_we, 1);
        chk("prio_addr", mem_addr, 10'h2AB);
        step();
        chk("prio_single", mem_we, 0);
        do_reset(1);

        // Read latency
        sc_req = 1; sc_addr = 10'h123;
        step();
        sc_req = 0;
        chk("lat_addr", mem_addr, 10'h123);
        chk("lat_rv_early", sc_rvalid, 0);
        step();
        chk("lat_rv", sc_rvalid, 1);
        chk("lat_data", sc_rdata, 8'hA5);
        step();

        // Clear with toggling scanout and an ignored restart
        track = 0; seen_wr = 0; done_obs = 0;
        clr_start = 1; step(); clr_start = 0;
        track = 1;
        run_clear(1, 1);
        track = 0;
        chk("clr_count", seen_wr, DEPTH);
        chk("clr_done_cnt", done_obs, 1);

        // Reset mid-clear, then a fresh clear from 0
        clr_start = 1; step(); clr_start = 0;
        for (int k = 0; k < 40 && m_caddr != 7; k++) step();
        rst = 1; step(); rst = 0;
        chk("abort_busy", clr_busy, 0);
        chk("abort_we", mem_we, 0);
        repeat (3) begin
            step();
            chk("abort_idle", mem_we, 0);
        end
        seen_wr = 0; done_obs = 0;
        clr_start = 1; step(); clr_start = 0;
        track = 1;
        run_clear(0, 0);
        track = 0;
        chk("clr2_count", seen_wr, DEPTH);
        chk("clr2_done", done_obs, 1);

        // Starvation flag
        do_reset(1);
        sc_req = 1; pl_valid = 1; pl_addr = 10'h011; pl_wdata = 8'h22;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("starve_seq", starve_flag, i >= SMAX);
        end
        sc_req = 0;
        step();
        pl_valid = 0;
        repeat (3) step();
        chk("starve_sticky", starve_flag, 1);
        do_reset(1);
        chk("starve_rst", starve_flag, 0);

        // Scanline bursts with a queue of plotter writes
        idx = 0;
        for (int line = 0; line < 2; line++) begin
            for (int c = 0; c < 800; c++) begin
                sc_req  = c < 640;
                sc_addr = AW'(c);
                if (!m_pend) begin
                    pl_valid = idx < 100;
                    pl_addr  = AW'($urandom);
                    pl_wdata = DW'($urandom);
                end
                step();
                if (pl_valid && !m_pend) idx++;
            end
        end
        pl_valid = 0; sc_req = 0;
        chk("burst_all", idx, 100);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            sc_req    = 1'($urandom);
            sc_addr   = AW'($urandom);
            clr_start = ($urandom_range(0, 99) == 0);
            if (!m_pend) begin
                pl_valid = 1'($urandom);
                pl_addr  = AW'($urandom);
                pl_wdata = DW'($urandom);
            end
            step();
        end
        rst = 0; idle_in(); pl_valid = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
